// File: rtl/cpu16_pkg.sv
// Shared CPU16 definitions: loader FSM states, frame start byte and instruction width.
package cpu16_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;
    localparam int         INSTR_W      = 16;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the CPU16 instruction RAM: MAGIC, LEN (BE), 2*LEN payload
// bytes, CSUM. Holds the CPU in reset while loading and releases it on a good checksum.
module prog_loader
    import cpu16_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]        MAGIC     = LOADER_MAGIC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [15:0]        words_loaded
);

    localparam logic [31:0] DEPTH_L = 32'(DEPTH);

    loader_state_t      r_state;
    loader_state_t      w_state_next;
    logic               r_in_ready;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [INSTR_W-1:0] r_mem_wdata;
    logic               r_cpu_hold;
    logic               r_done;
    logic               r_error;
    logic [15:0]        r_words;
    logic [15:0]        r_len;
    logic [7:0]         r_len_hi;
    logic [7:0]         r_hi;
    logic [7:0]         r_csum;

    logic               w_accept;
    logic [15:0]        w_len_full;
    logic               w_len_too_big;
    logic [15:0]        w_words_inc;

    assign w_accept      = in_valid && r_in_ready;
    assign w_len_full    = {r_len_hi, in_data};
    assign w_len_too_big = 32'(w_len_full) > DEPTH_L;
    assign w_words_inc   = r_words + 16'd1;

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            case (r_state)
                IDLE, DONE, ERROR: if (in_data == MAGIC) w_state_next = LEN_HI;
                LEN_HI:            w_state_next = LEN_LO;
                LEN_LO: begin
                    if (w_len_too_big)            w_state_next = ERROR;
                    else if (w_len_full == 16'd0) w_state_next = CHECK;
                    else                          w_state_next = DATA_HI;
                end
                DATA_HI:           w_state_next = DATA_LO;
                DATA_LO:           w_state_next = (w_words_inc == r_len) ? CHECK : DATA_HI;
                CHECK:             w_state_next = (in_data == r_csum) ? DONE : ERROR;
                default:           w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_words     <= '0;
            r_len       <= '0;
            r_len_hi    <= '0;
            r_hi        <= '0;
            r_csum      <= '0;
        end else begin
            r_in_ready <= 1'b1;
            r_mem_we   <= 1'b0;
            r_state    <= w_state_next;
            if (w_accept) begin
                case (r_state)
                    IDLE, DONE, ERROR: begin
                        if (in_data == MAGIC) begin
                            r_cpu_hold <= 1'b1;
                            r_done     <= 1'b0;
                            r_error    <= 1'b0;
                            r_words    <= '0;
                            r_csum     <= '0;
                        end
                    end
                    LEN_HI: r_len_hi <= in_data;
                    LEN_LO: begin
                        r_len <= w_len_full;
                        if (w_len_too_big) r_error <= 1'b1;
                    end
                    DATA_HI: begin
                        r_hi   <= in_data;
                        r_csum <= r_csum + in_data;
                    end
                    // Word is committed on the cycle after its lo byte is accepted.
                    DATA_LO: begin
                        r_csum      <= r_csum + in_data;
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= {r_hi, in_data};
                        r_mem_addr  <= BASE_ADDR + ADDR_W'(r_words);
                        r_words     <= w_words_inc;
                    end
                    CHECK: begin
                        if (in_data == r_csum) begin
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule
